time_syn_calc: RTL and testbench

Downstream consumer of the control-port time-sync receiver. It owns the ToR's 64-bit local time counter and issues a sync request on each slot start. It captures the controller's standard time and the echoed request timestamp, then computes one-way link delay as half the round trip. It then loads a corrected local time. Its request output feeds the control-port transmit framer.

---
 rtl/time_syn_pkg.sv | 30 +++
 rtl/time_syn_delay_filt.sv | 79 +++++++
 rtl/time_syn_calc.sv | 240 ++++++++++++++++++++++++
 tb/tb_time_syn_calc.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/time_syn_pkg.sv
// -----------------------------------------------------------------------------
// time_syn_pkg
// Shared types and widths for the time-sync calculator and its delay filter.
//   TIME_W      : width of local / controller time values (ns)
//   DELAY_W     : width of the one-way link delay (ns)
//   syn_state_e : sync FSM state encoding
//   half_rtt()  : one-way delay from a round trip, 64-bit modular
// -----------------------------------------------------------------------------
package time_syn_pkg;

   localparam int TIME_W  = 64;
   localparam int DELAY_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_REQ      = 2'd1,
      ST_WAIT_RSP = 2'd2,
      ST_ADJUST   = 2'd3
   } syn_state_e;

   // Round trip is measured on the local clock only (T4 - T1), so a wrap of
   // the 64-bit counter between the two stamps is harmless.
   function automatic logic [TIME_W-1:0] half_rtt(input logic [TIME_W-1:0] t4,
                                                  input logic [TIME_W-1:0] t1);
      logic [TIME_W-1:0] rtt;
      rtt = t4 - t1;
      return rtt >> 1;
   endfunction

endpackage

// File: rtl/time_syn_delay_filt.sv
// -----------------------------------------------------------------------------
// time_syn_delay_filt
// Four-sample moving average of accepted link delays. The first sample after
// reset pre-fills the whole window so the average starts at that value
// instead of ramping up from zero. The average is registered: it is valid on
// the cycle after the push.
// Ports:
//   clk_i    : clock
//   rst_i    : synchronous active-high reset
//   push_i   : one-cycle strobe, sample_i enters the window
//   sample_i : accepted raw delay (ns)
//   avg_o    : (sum of last four samples) >> 2
// -----------------------------------------------------------------------------
module time_syn_delay_filt
   import time_syn_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               push_i,
   input  logic [DELAY_W-1:0] sample_i,
   output logic [DELAY_W-1:0] avg_o
);

   localparam int DEPTH = 4;
   localparam int SUM_W = DELAY_W + 2;

   // win_q[0] is the newest stored sample
   logic [DELAY_W-1:0] win_q [DEPTH];
   logic               primed_q;
   logic [SUM_W-1:0]   sum_d;
   logic [DELAY_W-1:0] avg_q;

   // Sum of the window as it will be after this push: the incoming sample
   // plus the three newest stored ones (the oldest drops out).
   always_comb begin
      sum_d = {2'b00, sample_i};
      if (primed_q) begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            sum_d = sum_d + {2'b00, win_q[i]};
         end
      end else begin
         sum_d = {sample_i, 2'b00};
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_tap
         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               win_q[gi] <= '0;
            end else if (push_i) begin
               if (!primed_q) begin
                  win_q[gi] <= sample_i;
               end else begin
                  if (gi == 0) begin
                     win_q[gi] <= sample_i;
                  end else begin
                     win_q[gi] <= win_q[(gi == 0) ? 0 : gi - 1];
                  end
               end
            end
         end
      end
   endgenerate

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         primed_q <= 1'b0;
         avg_q    <= '0;
      end else if (push_i) begin
         primed_q <= 1'b1;
         avg_q    <= sum_d[SUM_W-1:2];
      end
   end

   assign avg_o = avg_q;

endmodule

// File: rtl/time_syn_calc.sv
// -----------------------------------------------------------------------------
// time_syn_calc
// Owns the ToR 64-bit local time. On each slot start it sends a sync request
// stamped with local time (T1), collects the controller's standard time (T2)
// and the echoed T1 (arrival stamped locally as T4), derives one-way delay as
// (T4 - T1) / 2 and loads local time = T2 + delay + period * edges-since-T2.
// In IDLE a broadcast time stamp can also re-load local time using the last
// accepted delay.
//
// Optional feature macro: TIME_SYN_DELAY_FILTER_EN
//   defined   -> accepted delays pass through a 4-sample moving average
//                (time_syn_delay_filt); ADJUST takes two cycles.
//   undefined -> raw delay used directly; ADJUST takes one cycle.
//
// Ports:
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_syn_start             : slot-start pulse
//   i_recv_std_time/_valid  : controller standard time T2
//   i_recv_return_ts/_valid : echoed request stamp T1
//   i_recv_time_stamp, i_recv_ts_valid : one-way broadcast time
//   o_req_valid, o_req_ts   : sync request pulse and its T1 stamp
//   o_local_time            : corrected local time (ns)
//   o_time_valid            : sticky, set by first accepted adjust
//   o_link_delay            : last accepted one-way delay (ns)
//   o_adj_pulse             : pulse on every local-time load
//   o_timeout               : pulse on response timeout or rejected delay
// -----------------------------------------------------------------------------
module time_syn_calc
   import time_syn_pkg::*;
#(
   parameter logic [7:0]  P_CLK_PERIOD_NS = 8'd4,
   parameter logic [15:0] P_TIMEOUT_CYC   = 16'd2000,
   parameter logic [31:0] P_DELAY_MAX     = 32'd100000
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_syn_start,
   input  logic [TIME_W-1:0]  i_recv_std_time,
   input  logic               i_recv_std_valid,
   input  logic [TIME_W-1:0]  i_recv_return_ts,
   input  logic               i_recv_return_valid,
   input  logic [TIME_W-1:0]  i_recv_time_stamp,
   input  logic               i_recv_ts_valid,
   output logic               o_req_valid,
   output logic [TIME_W-1:0]  o_req_ts,
   output logic [TIME_W-1:0]  o_local_time,
   output logic               o_time_valid,
   output logic [DELAY_W-1:0] o_link_delay,
   output logic               o_adj_pulse,
   output logic               o_timeout
);

   localparam logic [TIME_W-1:0] STEP        = {{(TIME_W-8){1'b0}}, P_CLK_PERIOD_NS};
   localparam logic [TIME_W-1:0] DELAY_LIMIT = {{(TIME_W-DELAY_W){1'b0}}, P_DELAY_MAX};
   localparam logic [15:0]       TIMEOUT_LAST = P_TIMEOUT_CYC - 16'd1;

   syn_state_e         state_q;
   logic [TIME_W-1:0]  local_time_q;
   logic [TIME_W-1:0]  req_ts_q;
   logic [TIME_W-1:0]  t1_q;
   logic [TIME_W-1:0]  t2_q;
   logic [TIME_W-1:0]  t4_q;
   logic [TIME_W-1:0]  bcast_ts_q;
   logic               bcast_pend_q;
   logic               std_flag_q;
   logic               ret_flag_q;
   logic [15:0]        to_cnt_q;
   logic [15:0]        age_q;
   logic               req_valid_q;
   logic               time_valid_q;
   logic               adj_pulse_q;
   logic               timeout_q;
   logic [DELAY_W-1:0] link_delay_q;

   logic               ret_match_d;
   logic [TIME_W-1:0]  delay_raw_d;
   logic               delay_bad_d;
   logic [DELAY_W-1:0] delay_use_d;
   logic [15:0]        n_edges_d;
   logic [TIME_W-1:0]  adj_time_d;
   logic [TIME_W-1:0]  bcast_time_d;
   logic               adj_reject_d;
   logic               adj_load_d;

   // An echo only counts if it carries the stamp of our outstanding request.
   assign ret_match_d  = i_recv_return_valid && (i_recv_return_ts == req_ts_q);
   assign delay_raw_d  = half_rtt(t4_q, t1_q);
   assign delay_bad_d  = delay_raw_d > DELAY_LIMIT;
   // age_q counts edges after T2 capture; the load edge itself adds one.
   assign n_edges_d    = age_q + 16'd1;
   assign adj_time_d   = t2_q + {{(TIME_W-DELAY_W){1'b0}}, delay_use_d}
                       + STEP * {{(TIME_W-16){1'b0}}, n_edges_d};
   // Broadcast stamp is registered one edge before the load, hence + STEP.
   assign bcast_time_d = bcast_ts_q + {{(TIME_W-DELAY_W){1'b0}}, link_delay_q} + STEP;

`ifdef TIME_SYN_DELAY_FILTER_EN
   logic               adj_stage_q;
   logic               filt_push_d;
   logic [DELAY_W-1:0] filt_avg;

   // First ADJUST cycle: screen the raw delay and feed the filter.
   // Second ADJUST cycle: load using the filter's registered average.
   assign filt_push_d  = (state_q == ST_ADJUST) && !adj_stage_q && !delay_bad_d;
   assign delay_use_d  = filt_avg;
   assign adj_reject_d = !adj_stage_q && delay_bad_d;
   assign adj_load_d   = adj_stage_q;

   time_syn_delay_filt u_delay_filt (
      .clk_i    (i_clk),
      .rst_i    (i_rst),
      .push_i   (filt_push_d),
      .sample_i (delay_raw_d[DELAY_W-1:0]),
      .avg_o    (filt_avg)
   );
`else
   assign delay_use_d  = delay_raw_d[DELAY_W-1:0];
   assign adj_reject_d = delay_bad_d;
   assign adj_load_d   = 1'b1;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= ST_IDLE;
         local_time_q <= '0;
         req_ts_q     <= '0;
         t1_q         <= '0;
         t2_q         <= '0;
         t4_q         <= '0;
         bcast_ts_q   <= '0;
         bcast_pend_q <= 1'b0;
         std_flag_q   <= 1'b0;
         ret_flag_q   <= 1'b0;
         to_cnt_q     <= '0;
         age_q        <= '0;
         req_valid_q  <= 1'b0;
         time_valid_q <= 1'b0;
         adj_pulse_q  <= 1'b0;
         timeout_q    <= 1'b0;
         link_delay_q <= '0;
`ifdef TIME_SYN_DELAY_FILTER_EN
         adj_stage_q  <= 1'b0;
`endif
      end else begin
         req_valid_q  <= 1'b0;
         adj_pulse_q  <= 1'b0;
         timeout_q    <= 1'b0;
         bcast_pend_q <= 1'b0;
         local_time_q <= local_time_q + STEP;

         if (std_flag_q) begin
            age_q <= age_q + 16'd1;
         end

         // Pending broadcast load (captured in IDLE on the previous edge)
         if (bcast_pend_q) begin
            local_time_q <= bcast_time_d;
            adj_pulse_q  <= 1'b1;
         end

`ifdef TIME_SYN_DELAY_FILTER_EN
         if (state_q != ST_ADJUST) begin
            adj_stage_q <= 1'b0;
         end
`endif

         case (state_q)
            ST_IDLE: begin
               if (i_recv_ts_valid) begin
                  bcast_ts_q   <= i_recv_time_stamp;
                  bcast_pend_q <= 1'b1;
               end
               if (i_syn_start) begin
                  state_q <= ST_REQ;
               end
            end

            ST_REQ: begin
               req_ts_q    <= local_time_q;
               req_valid_q <= 1'b1;
               std_flag_q  <= 1'b0;
               ret_flag_q  <= 1'b0;
               to_cnt_q    <= '0;
               age_q       <= '0;
               state_q     <= ST_WAIT_RSP;
            end

            ST_WAIT_RSP: begin
               if (i_recv_std_valid) begin
                  t2_q       <= i_recv_std_time;
                  std_flag_q <= 1'b1;
                  age_q      <= '0;
               end
               if (ret_match_d) begin
                  t1_q       <= i_recv_return_ts;
                  t4_q       <= local_time_q;
                  ret_flag_q <= 1'b1;
               end
               // A completing response wins over a timeout on the same edge.
               if ((std_flag_q || i_recv_std_valid) && (ret_flag_q || ret_match_d)) begin
                  state_q <= ST_ADJUST;
               end else if (to_cnt_q == TIMEOUT_LAST) begin
                  timeout_q <= 1'b1;
                  state_q   <= ST_IDLE;
               end else begin
                  to_cnt_q <= to_cnt_q + 16'd1;
               end
            end

            ST_ADJUST: begin
               if (adj_reject_d) begin
                  timeout_q <= 1'b1;
                  state_q   <= ST_IDLE;
               end else if (adj_load_d) begin
                  link_delay_q <= delay_use_d;
                  local_time_q <= adj_time_d;
                  adj_pulse_q  <= 1'b1;
                  time_valid_q <= 1'b1;
                  state_q      <= ST_IDLE;
               end
`ifdef TIME_SYN_DELAY_FILTER_EN
               else begin
                  adj_stage_q <= 1'b1;
               end
`endif
            end

            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign o_req_valid  = req_valid_q;
   assign o_req_ts     = req_ts_q;
   assign o_local_time = local_time_q;
   assign o_time_valid = time_valid_q;
   assign o_link_delay = link_delay_q;
   assign o_adj_pulse  = adj_pulse_q;
   assign o_timeout    = timeout_q;

endmodule

// File: tb/tb_time_syn_calc.sv
// -----------------------------------------------------------------------------
// tb_time_syn_calc
// Self-checking bench for time_syn_calc. Local time is modelled as
// "last loaded value + 4 ns per elapsed clock"; round trips are described by
// the edge (after the request edge) on which T2 and the echo arrive, from
// which the delay, N and the loaded time follow arithmetically. A delay limit
// of 1000 ns is used so rejection is reachable within the response timeout.
// -----------------------------------------------------------------------------
module tb_time_syn_calc;

   localparam logic [31:0] DMAX = 32'd1000;

   logic        clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_syn_start = 1'b0;
   logic [63:0] i_recv_std_time = '0;
   logic        i_recv_std_valid = 1'b0;
   logic [63:0] i_recv_return_ts = '0;
   logic        i_recv_return_valid = 1'b0;
   logic [63:0] i_recv_time_stamp = '0;
   logic        i_recv_ts_valid = 1'b0;
   logic        o_req_valid;
   logic [63:0] o_req_ts;
   logic [63:0] o_local_time;
   logic        o_time_valid;
   logic [31:0] o_link_delay;
   logic        o_adj_pulse;
   logic        o_timeout;

   always #5 clk = ~clk;

   time_syn_calc #(
      .P_CLK_PERIOD_NS (8'd4),
      .P_TIMEOUT_CYC   (16'd2000),
      .P_DELAY_MAX     (DMAX)
   ) dut (
      .i_clk               (clk),
      .i_rst               (i_rst),
      .i_syn_start         (i_syn_start),
      .i_recv_std_time     (i_recv_std_time),
      .i_recv_std_valid    (i_recv_std_valid),
      .i_recv_return_ts    (i_recv_return_ts),
      .i_recv_return_valid (i_recv_return_valid),
      .i_recv_time_stamp   (i_recv_time_stamp),
      .i_recv_ts_valid     (i_recv_ts_valid),
      .o_req_valid         (o_req_valid),
      .o_req_ts            (o_req_ts),
      .o_local_time        (o_local_time),
      .o_time_valid        (o_time_valid),
      .o_link_delay        (o_link_delay),
      .o_adj_pulse         (o_adj_pulse),
      .o_timeout           (o_timeout)
   );

   int          checks = 0;
   int          errors = 0;
   logic [63:0] cyc = '0;
   logic [63:0] lt_base = '0;
   logic [63:0] lt_cyc = '0;
   logic [31:0] link_m = '0;
   logic        tv_m = 1'b0;
   logic [31:0] hist[$];

   typedef struct {
      int          js;
      int          jr;
      logic [63:0] t2;
      logic [31:0] exp_delay;
      bit          exp_ok;
      int          exp_n;
   } vec_t;

   vec_t tbl[5];

   task automatic cycle();
      @(posedge clk);
      #1;
      cyc = cyc + 64'd1;
   endtask

   function automatic logic [63:0] exp_lt();
      return lt_base + 64'd4 * (cyc - lt_cyc);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Delay that ends up on o_link_delay once d is accepted.
   function automatic logic [31:0] accept_delay(input logic [31:0] d);
`ifdef TIME_SYN_DELAY_FILTER_EN
      logic [33:0] s;
      s = '0;
      if (hist.size() == 0) repeat (3) hist.push_back(d);
      hist.push_back(d);
      if (hist.size() > 4) void'(hist.pop_front());
      foreach (hist[i]) s = s + {2'b00, hist[i]};
      return s[33:2];
`else
      return d;
`endif
   endfunction

   task automatic clear_inputs();
      i_syn_start         = 1'b0;
      i_recv_std_valid    = 1'b0;
      i_recv_return_valid = 1'b0;
      i_recv_ts_valid     = 1'b0;
   endtask

   task automatic do_reset(input int n);
      clear_inputs();
      i_rst = 1'b1;
      repeat (n) cycle();
      i_rst   = 1'b0;
      lt_base = '0;
      lt_cyc  = cyc;
      link_m  = '0;
      tv_m    = 1'b0;
      hist.delete();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_local"}, o_local_time, 64'd0);
      chk({tag, "_req_valid"}, o_req_valid, 64'd0);
      chk({tag, "_req_ts"}, o_req_ts, 64'd0);
      chk({tag, "_time_valid"}, o_time_valid, 64'd0);
      chk({tag, "_link"}, o_link_delay, 64'd0);
      chk({tag, "_adj"}, o_adj_pulse, 64'd0);
      chk({tag, "_timeout"}, o_timeout, 64'd0);
   endtask

   task automatic do_request(output logic [63:0] t1);
      i_syn_start = 1'b1;
      cycle();
      i_syn_start = 1'b0;
      t1 = exp_lt();          // local time held at the REQ edge
      cycle();
      chk("req_valid", o_req_valid, 64'd1);
      chk("req_ts", o_req_ts, t1);
   endtask

   // js / jr: edge index (1 = first edge after the request edge) of T2 / echo.
   task automatic roundtrip(input int js, input int jr, input logic [63:0] t2,
                            input logic [31:0] exp_delay, input bit exp_ok, input int exp_n);
      logic [63:0] t1;
      logic [31:0] used;
      int          m;
      int          n;
      do_request(t1);
      m = (js > jr) ? js : jr;
      for (int j = 1; j <= m; j++) begin
         i_recv_std_valid    = (j == js);
         i_recv_std_time     = t2;
         i_recv_return_valid = (j == jr);
         i_recv_return_ts    = t1;
         cycle();
      end
      clear_inputs();
      cycle();
      if (!exp_ok) begin
         chk("rej_timeout", o_timeout, 64'd1);
         chk("rej_adj", o_adj_pulse, 64'd0);
         chk("rej_link", o_link_delay, link_m);
         chk("rej_local", o_local_time, exp_lt());
      end else begin
         n = exp_n;
`ifdef TIME_SYN_DELAY_FILTER_EN
         cycle();
         n = n + 1;
`endif
         used    = accept_delay(exp_delay);
         link_m  = used;
         tv_m    = 1'b1;
         lt_base = t2 + {32'd0, used} + 64'd4 * n;
         lt_cyc  = cyc;
         chk("adj_pulse", o_adj_pulse, 64'd1);
         chk("adj_timeout", o_timeout, 64'd0);
         chk("adj_link", o_link_delay, link_m);
         chk("adj_local", o_local_time, lt_base);
         chk("adj_time_valid", o_time_valid, 64'd1);
      end
      $display("roundtrip js=%0d jr=%0d delay=%0d ok=%0d link=%0d", js, jr, exp_delay, exp_ok, o_link_delay);
      cycle();
      chk("post_adj", o_adj_pulse, 64'd0);
      chk("post_timeout", o_timeout, 64'd0);
      chk("post_local", o_local_time, exp_lt());
   endtask

   task automatic broadcast(input logic [63:0] ts);
      i_recv_ts_valid   = 1'b1;
      i_recv_time_stamp = ts;
      cycle();
      i_recv_ts_valid = 1'b0;
      chk("bc_hold_local", o_local_time, exp_lt());
      chk("bc_hold_adj", o_adj_pulse, 64'd0);
      cycle();
      lt_base = ts + {32'd0, link_m} + 64'd4;
      lt_cyc  = cyc;
      chk("bc_local", o_local_time, lt_base);
      chk("bc_adj", o_adj_pulse, 64'd1);
      chk("bc_time_valid", o_time_valid, tv_m);
      $display("broadcast ts=%0d local=%0d", ts, o_local_time);
   endtask

   task automatic timeout_run(input bit bad_echo);
      logic [63:0] t1;
      int          pulses;
      int          at;
      int          adj;
      pulses = 0;
      at     = 0;
      adj    = 0;
      do_request(t1);
      for (int i = 1; i <= 2100; i++) begin
         i_recv_std_valid    = bad_echo && (i == 5);
         i_recv_std_time     = 64'd777;
         i_recv_return_valid = bad_echo && (i == 10);
         i_recv_return_ts    = t1 ^ 64'd1;
         cycle();
         if (o_timeout) begin
            pulses++;
            if (at == 0) at = i;
         end
         if (o_adj_pulse) adj++;
      end
      clear_inputs();
      chk("to_pulses", pulses, 64'd1);
      chk("to_edge", at, 64'd2000);
      chk("to_adj", adj, 64'd0);
      chk("to_local", o_local_time, exp_lt());
      chk("to_link", o_link_delay, link_m);
      chk("to_time_valid", o_time_valid, tv_m);
      $display("timeout bad_echo=%0d pulses=%0d at=%0d", bad_echo, pulses, at);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int          fexp[4];
      int          fjr[4];
      int          js;
      int          jr;
      int          mm;
      logic [31:0] d;

      // Reset state, then free-running count
      do_reset(3);
      chk_all_zero("reset");
      repeat (10) cycle();
      chk("idle10_local", o_local_time, 64'd40);
      chk("idle10_adj", o_adj_pulse, 64'd0);
      $display("reset+idle local=%0d", o_local_time);

      // Delay sequence 100,100,100,200 from a clean reset
      fjr = '{50, 50, 50, 100};
`ifdef TIME_SYN_DELAY_FILTER_EN
      fexp = '{100, 100, 100, 125};
`else
      fexp = '{100, 100, 100, 200};
`endif
      for (int i = 0; i < 4; i++) begin
         roundtrip(fjr[i], fjr[i], 64'd2_000_000 * (i + 1), 32'(2 * fjr[i]), 1'b1, 1);
         chk("seq_link", o_link_delay, fexp[i]);
      end

      // Table-driven round trips
      tbl[0] = '{48,  50,  64'd1_000_000,          32'd100,  1'b1, 3};
      tbl[1] = '{30,  30,  64'd5_000,              32'd60,   1'b1, 1};
      tbl[2] = '{600, 600, 64'd7,                  32'd1200, 1'b0, 0};
      tbl[3] = '{10,  500, 64'hFFFF_FFFF_FFFF_FF00, 32'd1000, 1'b1, 491};
      tbl[4] = '{520, 501, 64'd123_456,            32'd1002, 1'b0, 0};
      for (int i = 0; i < 5; i++) begin
         roundtrip(tbl[i].js, tbl[i].jr, tbl[i].t2, tbl[i].exp_delay, tbl[i].exp_ok, tbl[i].exp_n);
      end

      // Broadcast load, response timeout, mismatched echo
      broadcast(64'd50_000_000);
      timeout_run(1'b0);
      timeout_run(1'b1);

      // Randomized traffic against the arithmetic model
      for (int k = 0; k < 10; k++) begin
         if ($urandom_range(0, 1) == 1) broadcast({$urandom, $urandom});
         repeat ($urandom_range(0, 3)) cycle();
         js = $urandom_range(1, 40);
         jr = $urandom_range(1, 560);
         mm = (js > jr) ? js : jr;
         d  = 32'(2 * jr);
         roundtrip(js, jr, {$urandom, $urandom}, d, d <= DMAX, mm + 1 - js);
      end

      // Reset in the middle of WAIT_RSP
      begin
         logic [63:0] t1;
         do_request(t1);
         repeat (5) cycle();
         i_rst = 1'b1;
         cycle();
         chk_all_zero("midrst");
         i_rst   = 1'b0;
         lt_base = '0;
         lt_cyc  = cyc;
         link_m  = '0;
         tv_m    = 1'b0;
         hist.delete();
         cycle();
         chk("midrst_resume", o_local_time, 64'd4);
         $display("mid-wait reset local=%0d", o_local_time);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
